// File: rtl/timer_pkg.sv
// timer_pkg: shared state/sel encodings, debounce default and BCD helper for time_entry.
package timer_pkg;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

    typedef enum logic [2:0] {IDLE, EDIT_M10, EDIT_M1, RUN, PAUSE} state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_M10  = 2'b10;
    localparam logic [1:0] SEL_M1   = 2'b01;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, level debouncer and rising-edge press pulse.
module btn_debounce
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic s1, s2, level, level_d, armed;
    logic [CW-1:0] cnt;

    // Synchronizer resets to "pressed" so a button held through reset stays disarmed until seen released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            level   <= 1'b0;
            level_d <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            level_d <= level;
            armed   <= armed | ~s2;
            if (s2 == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end

    assign press = level & ~level_d & armed;
endmodule

// File: rtl/time_entry.sv
// time_entry: button-driven MM entry for a countdown, with load/CE handshake.
module time_entry
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_start,
    input  logic       timer_done,
    output logic [3:0] min10,
    output logic [3:0] min1,
    output logic       load,
    output logic       CE,
    output logic [1:0] sel
);
    logic p_mode, p_inc, p_start, pm, ps, pi;
    state_t state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode  (.clk(clk), .reset(reset), .btn(btn_mode),  .press(p_mode));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc   (.clk(clk), .reset(reset), .btn(btn_inc),   .press(p_inc));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (.clk(clk), .reset(reset), .btn(btn_start), .press(p_start));

    assign pm = p_mode;
    assign ps = p_start & ~p_mode;
    assign pi = p_inc & ~p_start & ~p_mode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            min10 <= 4'd0;
            min1  <= 4'd0;
            load  <= 1'b0;
            CE    <= 1'b0;
            sel   <= SEL_NONE;
        end else begin
            load <= 1'b0;
            CE   <= 1'b0;
            case (state)
                IDLE:
                    if (pm) begin
                        state <= EDIT_M10;
                        sel   <= SEL_M10;
                    end else if (ps && {min10, min1} != 8'h00) begin
                        state <= RUN;
                        load  <= 1'b1;
                    end
                EDIT_M10:
                    if (pm) begin
                        state <= EDIT_M1;
                        sel   <= SEL_M1;
                    end else if (pi)
                        min10 <= bcd_inc(min10);
                EDIT_M1:
                    if (pm) begin
                        state <= IDLE;
                        sel   <= SEL_NONE;
                        load  <= 1'b1;
                    end else if (pi)
                        min1 <= bcd_inc(min1);
                // timer_done is stale while the countdown is still capturing the load
                RUN:
                    if (timer_done && !load)
                        state <= IDLE;
                    else if (ps)
                        state <= PAUSE;
                    else
                        CE <= 1'b1;
                PAUSE:
                    if (pm) begin
                        state <= IDLE;
                        load  <= 1'b1;
                    end else if (ps)
                        state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable clk cycles before a button level is accepted (10 ms at 100 MHz).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 btn_mode  input  1  raw, asynchronous push-button; advances the edit cursor.
REQ-005 btn_inc  input  1  raw, asynchronous push-button; increments the selected digit.
REQ-006 btn_start  input  1  raw, asynchronous push-button; start/pause toggle.
REQ-007 timer_done  input  1  high while the downstream countdown reads 00:00.
REQ-008 min10  output  4  BCD tens-of-minutes value presented to the countdown.
REQ-009 min1  output  4  BCD units-of-minutes value presented to the countdown.
REQ-010 load  output  1  one-cycle pulse; countdown captures min10/min1.
REQ-011 CE  output  1  count enable to the countdown.
REQ-012 sel  output  2  edit cursor: 00 none, 10 tens digit, 01 units digit (display blink hint).

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer that updates its level only after DEBOUNCE_CYCLES identical samples.
REQ-014 Each debounced level SHALL yield a one-cycle press pulse on its 0->1 transition only; release and held levels generate nothing.
REQ-015 FSM states: IDLE, EDIT_M10, EDIT_M1, RUN, PAUSE.
REQ-016 IDLE: press mode -> EDIT_M10; press start with {min10,min1} != 00 -> RUN; press start with 00 -> stay IDLE.
REQ-017 EDIT_M10: press inc -> min10 = (min10==9) ? 0 : min10+1; press mode -> EDIT_M1.
REQ-018 EDIT_M1: press inc -> min1 wraps 9->0 identically; press mode -> IDLE with load=1 in the transition cycle.
REQ-019 EDIT states ignore start.
REQ-020 RUN: CE=1; press start -> PAUSE; timer_done=1 -> IDLE (timer_done wins over a same-cycle start press).
REQ-021 PAUSE: CE=0; press start -> RUN; press mode -> IDLE with load=1 (re-arm with held value).
REQ-022 Simultaneous press pulses in one cycle: only the highest priority acts, in the order mode > start > inc; the others are dropped.
REQ-023 load SHALL be registered, high exactly one cycle per qualifying transition, and never high in the same cycle as a CE 0->1 edge.
REQ-024 CE SHALL be registered and high only in RUN; sel = 10 in EDIT_M10, 01 in EDIT_M1, else 00.
REQ-025 min10/min1 SHALL hold their value outside the EDIT states and never leave 0..9.
REQ-026 The transition IDLE->RUN SHALL pulse load in the IDLE->RUN cycle, with CE rising one cycle later.

Reset
REQ-027 While reset=0: state IDLE, min10=0, min1=0, load=0, CE=0, sel=00, debounced levels 0, debounce counters 0.
REQ-028 Reset asserted mid-edit or mid-run SHALL abort immediately with no load pulse; a button held across reset release produces no press until released and pressed again.

Structure
REQ-029 Shared package timer_pkg SHALL hold the state encodings, the sel encodings and the DEBOUNCE_CYCLES default.
REQ-030 Sub-module btn_debounce (synchronizer, counter, edge pulse) SHALL be instantiated three times; the FSM and digit registers live in time_entry.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Raw inc glitch high for 3 cycles in EDIT_M10 -> min10 unchanged.
REQ-032 From reset: mode, inc x3, mode, inc x10, mode -> min10=3, min1=0 (wrapped), a single load pulse, then sel=00.
REQ-033 min10=0, min1=5, press start -> load for 1 cycle, then CE=1; press start -> CE=0 (PAUSE); press start -> CE=1.
REQ-034 In RUN, drive timer_done=1 and a start press in the same cycle -> IDLE, CE=0, and no transition to PAUSE.
REQ-035 In IDLE with 00, press start -> CE stays 0 and no load pulse; mode and inc press pulses coincident in EDIT_M10 -> EDIT_M1 and min10 unchanged.
REQ-036 Assert reset during EDIT_M1 with min1=7 -> all outputs return to their reset values asynchronously, and load stays 0.
